i281_datamem_display: RTL and testbench
=======================================

// Module: i281_datamem_display
// PURPOSE
//  Downstream viewer for the i281 multicycle CPU: consumes the 16 data-memory
//  bytes exported by the toplevel (datamem0..datamem15) and shows one word at a
//  time on three 7-segment digits: address, high nibble, low nibble.
//  Selection advances by a step button or an automatic dwell timer, so the
//  board lets an operator inspect memory while the CPU is running.
// PARAMETERS
//  DWELL_CYCLES    50_000_000  clock cycles per word in auto-scan mode (>=2)
//  SEG_ACTIVE_LOW  1           1: segment on = 0 (DE-series boards); 0: on = 1
// PORTS
//  clock        in   1    system clock, shared with the CPU
//  reset        in   1    synchronous, active-high
//  datamem_flat in   128  {datamem15,...,datamem0}; byte i = [8*i+7:8*i]
//  step         in   1    debounced button level; rising edge = next word
//  auto_en      in   1    level; 1 = auto-scan, 0 = manual
//  cur_addr     out  4    index of the displayed word
//  addr_seg     out  7    {g,f,e,d,c,b,a} hex digit of cur_addr
//  hi_seg       out  7    hex digit of displayed byte [7:4]
//  lo_seg       out  7    hex digit of displayed byte [3:0]
//  changed      out  1    displayed word modified since last viewed (optional)
// BEHAVIOUR
//  - One clock; reset is synchronous, active-high; all flops reset on the
//    clock edge where reset=1.
//  - Reset values: cur_addr=0, dwell count=0, step_q=0, state=MANUAL,
//    addr_seg/hi_seg/lo_seg = blank (all segments off per SEG_ACTIVE_LOW),
//    changed=0.
//  - Step edge: step_q registers step; edge = step & ~step_q. One edge = exactly
//    one advance; held button gives no repeats.
//  - FSM, two states, evaluated each cycle from auto_en:
//      MANUAL: advance on step edge only. auto_en=1 -> AUTO, dwell count := 0.
//      AUTO:   dwell count increments; at DWELL_CYCLES-1 advance, count := 0.
//              auto_en=0 -> MANUAL, count held at 0. Step edge in AUTO
//              advances and clears count.
//  - Simultaneous dwell expiry and step edge: advance by exactly one.
//  - Advance: cur_addr := cur_addr + 1, modulo 16 (15 -> 0).
//  - Datapath: byte = datamem_flat[8*cur_addr +: 8] using the registered
//    cur_addr. Segment outputs are registered from that byte and cur_addr.
//    Latency is 1 cycle from a cur_addr or memory change to the segment
//    outputs. Memory updates by the CPU appear live, with no latching.
//  - Hex encoding: standard 0-F glyphs (b and d lowercase). Inverted when
//    SEG_ACTIVE_LOW=1.
//  - Reset mid-scan: next cycle after reset deasserts shows word 0. The state
//    is MANUAL regardless of auto_en until the first non-reset cycle samples it.
// CONFIGURATION
//  CHANGE_HIGHLIGHT_EN defined:
//    - 16x8 shadow; loaded with datamem_flat on every reset cycle.
//    - changed_mask[i] set when byte i != shadow[i].
//    - On each advance, shadow[old addr] := current byte and
//      changed_mask[old addr] := 0. A write on that same cycle is absorbed
//      into the shadow, so it is not flagged.
//    - changed = registered changed_mask[cur_addr], with the same 1-cycle
//      latency as the segment outputs.
//  CHANGE_HIGHLIGHT_EN undefined: no shadow logic; changed tied to 0; port kept.
// TESTING  (DWELL_CYCLES=8, SEG_ACTIVE_LOW=1)
//  1 Reset held 3 cycles, datamem0=8'h3C -> during reset all segs 7'h7F.
//    1 cycle after release: addr_seg=7'h40 ("0"), hi_seg=7'h30 ("3"),
//    lo_seg=7'h46 ("C").
//  2 Manual mode, 17 step pulses, each 1 cycle high with 3 low between ->
//    cur_addr goes 1..15,0,1. Step held high 20 cycles -> exactly one advance.
//  3 auto_en=1 from cur_addr=14 -> advances every 8 cycles: 15, 0, 1.
//    Step edge on the expiry cycle -> +1 only. auto_en=0 -> cur_addr frozen.
//  4 cur_addr=5, datamem5 changes 8'h00->8'hA7 -> next cycle hi_seg=7'h08
//    ("A"), lo_seg=7'h78 ("7").
//  5 [CHANGE_HIGHLIGHT_EN] write datamem9=8'h11 while viewing word 3, then step
//    to 9 -> changed=1. Step to 10 and back to 9 -> changed=0. Undefined build
//    -> changed=0 throughout.

Source files
------------

// File: rtl/i281_datamem_display.sv
// rtl/i281_datamem_display.sv - i281 data-memory viewer on three 7-segment digits
//
// Shows one of the 16 CPU data-memory bytes at a time. The address digit
// shows the word index and the other two digits show the byte as hex.
// The selection advances on a rising edge of step, or every DWELL_CYCLES
// clocks while auto_en is high.
//
// Optional feature macro: CHANGE_HIGHLIGHT_EN (adds a 16x8 shadow that drives
// changed; when the macro is undefined, changed is tied to 0).
//
// Ports:
//   clock        in   1    system clock shared with the CPU
//   reset        in   1    synchronous, active-high
//   datamem_flat in   128  {datamem15..datamem0}, byte i = [8*i+7:8*i]
//   step         in   1    debounced button level, rising edge = next word
//   auto_en      in   1    1 = auto-scan, 0 = manual
//   cur_addr     out  4    index of the displayed word
//   addr_seg     out  7    {g,f,e,d,c,b,a} glyph of cur_addr
//   hi_seg       out  7    glyph of displayed byte [7:4]
//   lo_seg       out  7    glyph of displayed byte [3:0]
//   changed      out  1    displayed word modified since it was last viewed
module i281_datamem_display #(
    parameter int DWELL_CYCLES   = 50_000_000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [127:0] datamem_flat,
    input  logic         step,
    input  logic         auto_en,
    output logic [3:0]   cur_addr,
    output logic [6:0]   addr_seg,
    output logic [6:0]   hi_seg,
    output logic [6:0]   lo_seg,
    output logic         changed
);

    localparam int       DW         = $clog2(DWELL_CYCLES);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [6:0]    SEG_BLANK  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    typedef enum logic {S_MANUAL = 1'b0, S_AUTO = 1'b1} state_t;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return SEG_ACTIVE_LOW ? ~s : s;
    endfunction

    state_t          state_q, state_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic [3:0]      cur_addr_q, cur_addr_d;
    logic            step_q;
    logic [6:0]      addr_seg_q, hi_seg_q, lo_seg_q;
    logic            step_edge;
    logic            dwell_run;
    logic            advance;
    logic [7:0]      cur_byte;

    assign step_edge = step & ~step_q;
    // Live read of the CPU memory through the registered index; no latching.
    assign cur_byte  = datamem_flat[{cur_addr_q, 3'b000} +: 8];

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_MANUAL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: the mode simply follows auto_en one cycle later.
    always_comb begin
        state_d = auto_en ? S_AUTO : S_MANUAL;
    end

    // Outputs of the FSM: dwell counter and address advance.
    // The timer only runs while already in AUTO and auto_en is still high, so
    // entering AUTO starts from a zero count and leaving it holds zero.
    // A step edge coinciding with expiry is one advance, not two.
    always_comb begin
        dwell_run  = (state_q == S_AUTO) && auto_en;
        advance    = step_edge || (dwell_run && (dwell_q == DWELL_LAST));
        dwell_d    = (dwell_run && !advance) ? dwell_q + 1'b1 : '0;
        cur_addr_d = advance ? cur_addr_q + 4'd1 : cur_addr_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dwell_q    <= '0;
            cur_addr_q <= 4'd0;
            step_q     <= 1'b0;
            addr_seg_q <= SEG_BLANK;
            hi_seg_q   <= SEG_BLANK;
            lo_seg_q   <= SEG_BLANK;
        end else begin
            dwell_q    <= dwell_d;
            cur_addr_q <= cur_addr_d;
            step_q     <= step;
            addr_seg_q <= hex7(cur_addr_q);
            hi_seg_q   <= hex7(cur_byte[7:4]);
            lo_seg_q   <= hex7(cur_byte[3:0]);
        end
    end

    assign cur_addr = cur_addr_q;
    assign addr_seg = addr_seg_q;
    assign hi_seg   = hi_seg_q;
    assign lo_seg   = lo_seg_q;

`ifdef CHANGE_HIGHLIGHT_EN
    logic [7:0] shadow_q [16];
    logic       changed_q;

    // Leaving a word refreshes its shadow with the byte as it is on that same
    // cycle, so a write landing exactly then is not flagged later.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                shadow_q[i] <= datamem_flat[8*i +: 8];
            end
            changed_q <= 1'b0;
        end else begin
            if (advance) begin
                shadow_q[cur_addr_q] <= cur_byte;
            end
            changed_q <= (cur_byte != shadow_q[cur_addr_q]);
        end
    end

    assign changed = changed_q;
`else
    assign changed = 1'b0;
`endif

endmodule

// File: tb/tb_i281_datamem_display.sv
// tb/tb_i281_datamem_display.sv - self-checking bench for i281_datamem_display
module tb_i281_datamem_display;

    localparam int DWELL = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic [127:0] datamem_flat;
    logic         step;
    logic         auto_en;
    logic [3:0]   cur_addr;
    logic [6:0]   addr_seg;
    logic [6:0]   hi_seg;
    logic [6:0]   lo_seg;
    logic         changed;

    logic [7:0]   mem [16];

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    int         m_addr;
    bit         m_auto;
    int         m_elapsed;
    bit         m_prev_step;
    logic [6:0] m_aseg, m_hseg, m_lseg;
    logic       m_changed;
    logic [7:0] m_shadow [16];

    logic [6:0] glyph [16];

    i281_datamem_display #(
        .DWELL_CYCLES  (DWELL),
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .datamem_flat(datamem_flat),
        .step        (step),
        .auto_en     (auto_en),
        .cur_addr    (cur_addr),
        .addr_seg    (addr_seg),
        .hi_seg      (hi_seg),
        .lo_seg      (lo_seg),
        .changed     (changed)
    );

    always #5 clock = ~clock;

    always_comb begin
        datamem_flat = '0;
        for (int i = 0; i < 16; i++) datamem_flat[8*i +: 8] = mem[i];
    end

    function automatic logic [6:0] seg_of(input int v);
        return ~glyph[v & 15];
    endfunction

    // One clock of the intended behaviour, using the inputs present before the edge.
    task automatic model_step();
        bit edge_seen, expire, adv;
        if (reset) begin
            m_addr = 0; m_auto = 0; m_elapsed = 0; m_prev_step = 0;
            m_aseg = 7'h7F; m_hseg = 7'h7F; m_lseg = 7'h7F; m_changed = 1'b0;
            for (int i = 0; i < 16; i++) m_shadow[i] = mem[i];
        end else begin
            edge_seen = step && !m_prev_step;
            expire    = m_auto && auto_en && (m_elapsed == DWELL - 1);
            adv       = edge_seen || expire;
            m_aseg = seg_of(m_addr);
            m_hseg = seg_of(int'(mem[m_addr]) / 16);
            m_lseg = seg_of(int'(mem[m_addr]) % 16);
`ifdef CHANGE_HIGHLIGHT_EN
            m_changed = (mem[m_addr] != m_shadow[m_addr]);
`else
            m_changed = 1'b0;
`endif
            if (adv) begin
                m_shadow[m_addr] = mem[m_addr];
                m_addr = (m_addr + 1) % 16;
            end
            m_elapsed   = (m_auto && auto_en && !adv) ? m_elapsed + 1 : 0;
            m_auto      = auto_en;
            m_prev_step = step;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        chk("cur_addr", {4'h0, cur_addr}, 8'(m_addr));
        chk("addr_seg", {1'b0, addr_seg}, {1'b0, m_aseg});
        chk("hi_seg",   {1'b0, hi_seg},   {1'b0, m_hseg});
        chk("lo_seg",   {1'b0, lo_seg},   {1'b0, m_lseg});
        chk("changed",  {7'h0, changed},  {7'h0, m_changed});
    endtask

    task automatic pulse();
        step = 1'b1; tick();
        step = 1'b0; tick(); tick(); tick();
    endtask

    task automatic goto_addr(input int target);
        for (int k = 0; k < 20 && m_addr != target; k++) pulse();
        chk("reach_addr", {4'h0, cur_addr}, 8'(target));
    endtask

    initial begin
        int t_last, gap, a0;
        glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h3C;
        mem[9] = 8'h22;
        reset = 1'b1; step = 1'b0; auto_en = 1'b0;

        // Reset held 3 cycles: blank segments
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("reset_blank_addr", {1'b0, addr_seg}, 8'h7F);
            chk("reset_blank_lo",   {1'b0, lo_seg},   8'h7F);
        end
        reset = 1'b0;
        tick();
        chk("post_reset_addr_seg", {1'b0, addr_seg}, 8'h40);
        chk("post_reset_hi_seg",   {1'b0, hi_seg},   8'h30);
        chk("post_reset_lo_seg",   {1'b0, lo_seg},   8'h46);

        // Manual stepping through the wrap
        for (int k = 1; k <= 17; k++) begin
            pulse();
            chk("manual_step", {4'h0, cur_addr}, 8'(k % 16));
        end
        step = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        step = 1'b0;
        tick();
        chk("held_step_once", {4'h0, cur_addr}, 8'd2);

        // Auto-scan from word 14
        goto_addr(14);
        auto_en = 1'b1;
        t_last = 0;
        for (int k = 0; k < 60 && m_addr != 1; k++) begin
            a0 = int'(cur_addr);
            tick();
            t_last++;
            if (int'(cur_addr) != a0) begin
                if (a0 != 14) chk("dwell_interval", 8'(t_last), 8'(DWELL));
                t_last = 0;
            end
        end
        chk("auto_reach_1", {4'h0, cur_addr}, 8'd1);
        for (int k = 0; k < 20 && !(m_auto && m_elapsed == DWELL - 1); k++) tick();
        a0 = m_addr;
        step = 1'b1;
        tick();
        chk("expiry_plus_step", {4'h0, cur_addr}, 8'((a0 + 1) % 16));
        step = 1'b0;
        auto_en = 1'b0;
        tick();
        a0 = int'(cur_addr);
        for (int k = 0; k < 20; k++) tick();
        chk("auto_off_frozen", {4'h0, cur_addr}, 8'(a0));

        // Live memory update on word 5
        goto_addr(5);
        mem[5] = 8'h00; tick(); tick();
        mem[5] = 8'hA7; tick();
        chk("live_hi_A", {1'b0, hi_seg}, 8'h08);
        chk("live_lo_7", {1'b0, lo_seg}, 8'h78);

        // Change highlight
        goto_addr(3);
        mem[9] = 8'h11;
        tick();
        goto_addr(9);
`ifdef CHANGE_HIGHLIGHT_EN
        chk("changed_set", {7'h0, changed}, 8'd1);
`else
        chk("changed_tied", {7'h0, changed}, 8'd0);
`endif
        goto_addr(10);
        goto_addr(9);
        chk("changed_clear", {7'h0, changed}, 8'd0);

        // Randomised phase against the model
        for (int k = 0; k < 600; k++) begin
            step    = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 40) == 0) auto_en = ~auto_en;
            if ($urandom_range(0, 5) == 0) mem[$urandom_range(0, 15)] = 8'($urandom);
            reset   = ($urandom_range(0, 150) == 0);
            tick();
        end
        reset = 1'b0; step = 1'b0; auto_en = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
